// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states,
// opcodes, and datapath mux/ALU select codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mem_wait_watchdog.sv
// Counts consecutive stalled cycles of one memory access and flags
// expiry when the budget is used up and memory is still not ready.
module mem_wait_watchdog #(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic clear,
  output logic expired
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // Clear has priority so an access that ends (or a trap) restarts at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)        cnt_d = '0;
    else if (waiting) cnt_d = cnt_q + 1'b1;
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = waiting && (cnt_q == WAIT_W'(WAIT_MAX));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE then per-opcode execute,
// memory and writeback states, with memory-stall watchdog and sticky
// illegal-opcode trap. Optional perf counters: MULTICYCLE_CTRL_PERF_CNT_EN.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       memto_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  state_e state_q, state_d;
  logic   ill_q, ill_d, to_q, to_d;
  logic   mem_state, wd_expired;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);

  mem_wait_watchdog #(.WAIT_MAX(WAIT_MAX), .WAIT_W(WAIT_W)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .waiting (mem_state && !mem_ready),
    .clear   (mem_ready || (state_d != state_q)),
    .expired (wd_expired)
  );

  // State and sticky trap flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
    end
  end

  // Next-state; a completing access beats the watchdog in the same cycle.
  always_comb begin
    state_d = state_q;
    ill_d   = ill_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)       state_d = S_DECODE;
        else if (wd_expired) begin state_d = S_TRAP; to_d = 1'b1; end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      begin state_d = S_TRAP; ill_d = 1'b1; end
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)       state_d = S_MEM_WB;
        else if (wd_expired) begin state_d = S_TRAP; to_d = 1'b1; end
      end
      S_MEM_WR: begin
        if (mem_ready)       state_d = S_FETCH;
        else if (wd_expired) begin state_d = S_TRAP; to_d = 1'b1; end
      end
      S_EXEC:   state_d = S_R_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore output decode; only the FETCH/MEM_WR handshakes look at mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    memto_reg     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUSRCB_B;
    alu_op        = ALU_OP_ADD;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUSRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = ALUSRCB_IMM_SH;
      S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = ALUSRCB_IMM; end
      S_MEM_RD:   begin mem_read = 1'b1; i_or_d = 1'b1; end
      S_MEM_WB:   begin reg_write = 1'b1; memto_reg = 1'b1; instr_done = 1'b1; end
      S_MEM_WR:   begin mem_write = 1'b1; i_or_d = 1'b1; instr_done = mem_ready; end
      S_EXEC:     begin alu_src_a = 1'b1; alu_op = ALU_OP_FUNCT; end
      S_R_WB:     begin reg_write = 1'b1; reg_dst = 1'b1; instr_done = 1'b1; end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_JUMP:     begin pc_write = 1'b1; pc_source = PCSRC_JUMP; instr_done = 1'b1; end
      default: ;
    endcase
  end

  assign illegal_op  = ill_q;
  assign mem_timeout = to_q;
  assign state       = state_q;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [31:0] cyc_q, ins_q;

  // Free-running activity counters; wrap silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_TRAP) cyc_q <= cyc_q + 32'd1;
      if (instr_done)                             ins_q <= ins_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
  assign instr_count = ins_q;
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized directed bench for multicycle_ctrl. Each instruction is
// expanded into its expected state sequence from opcode class and chosen
// memory wait counts; outputs are checked against a per-state table.
module tb_multicycle_ctrl;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MADDR = 3,
                 ST_MRD = 4, ST_MWB = 5, ST_MWR = 6, ST_EXEC = 7,
                 ST_RWB = 8, ST_BR = 9, ST_J = 10, ST_TRAP = 11;

  logic clk = 1'b0, rst;
  logic [5:0] opcode;
  logic mem_ready;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic reg_dst, memto_reg, reg_write, alu_src_a, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic illegal_op, mem_timeout;
  logic [3:0] state;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_count, instr_count;
`endif

  multicycle_ctrl #(.WAIT_MAX(15), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .memto_reg(memto_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .state(state)
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, done_seen = 0;
  logic exp_ill = 1'b0, exp_to = 1'b0;

  wire [16:0] ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                      ir_write, reg_dst, memto_reg, reg_write, alu_src_a,
                      alu_src_b, alu_op, pc_source, instr_done};

  // Expected control word for a state, straight from the output table.
  function automatic logic [16:0] exp_ctrl(input int st, input logic rdy);
    logic pcw = 0, pcwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, rd = 0;
    logic m2r = 0, rw = 0, asa = 0, idn = 0;
    logic [1:0] asb = 0, aop = 0, psrc = 0;
    case (st)
      ST_FETCH:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      ST_DECODE: asb = 2'b11;
      ST_MADDR:  begin asa = 1; asb = 2'b10; end
      ST_MRD:    begin mr = 1; iod = 1; end
      ST_MWB:    begin rw = 1; m2r = 1; idn = 1; end
      ST_MWR:    begin mw = 1; iod = 1; idn = rdy; end
      ST_EXEC:   begin asa = 1; aop = 2'b10; end
      ST_RWB:    begin rw = 1; rd = 1; idn = 1; end
      ST_BR:     begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; idn = 1; end
      ST_J:      begin pcw = 1; psrc = 2'b10; idn = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, idn};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2b || op == 6'h04 || op == 6'h02;
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check shortly after.
  task automatic step(input logic rdy, input int st, input logic [5:0] op);
    @(negedge clk);
    mem_ready = rdy;
    opcode    = op;
    #1;
    chk("state", 32'(state), 32'(st));
    chk("ctrl", 32'(ctrl), 32'(exp_ctrl(st, rdy)));
    chk("illegal_op", 32'(illegal_op), 32'(exp_ill));
    chk("mem_timeout", 32'(mem_timeout), 32'(exp_to));
    if (instr_done === 1'b1) done_seen++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_ill = 1'b0;
    exp_to  = 1'b0;
    #1;
    chk("rst_state", 32'(state), ST_IDLE);
    chk("rst_ctrl", 32'(ctrl), 0);
    chk("rst_flags", 32'({illegal_op, mem_timeout}), 0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = rbit();
    #1;
    chk("idle_state", 32'(state), ST_IDLE);
    chk("idle_ctrl", 32'(ctrl), 0);
  endtask

  // Whole legal instruction: wf fetch stalls, wm data-access stalls.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    done_seen = 0;
    for (int i = 0; i < wf; i++) step(1'b0, ST_FETCH, rnd_op());
    step(1'b1, ST_FETCH, rnd_op());
    step(rbit(), ST_DECODE, op);
    case (op)
      6'h00: begin step(rbit(), ST_EXEC, rnd_op()); step(rbit(), ST_RWB, rnd_op()); end
      6'h23: begin
        step(rbit(), ST_MADDR, op);
        for (int i = 0; i < wm; i++) step(1'b0, ST_MRD, rnd_op());
        step(1'b1, ST_MRD, rnd_op());
        step(rbit(), ST_MWB, rnd_op());
      end
      6'h2b: begin
        step(rbit(), ST_MADDR, op);
        for (int i = 0; i < wm; i++) step(1'b0, ST_MWR, rnd_op());
        step(1'b1, ST_MWR, rnd_op());
      end
      6'h04: step(rbit(), ST_BR, rnd_op());
      default: step(rbit(), ST_J, rnd_op());
    endcase
    chk("done_pulses", done_seen, 1);
  endtask

  initial begin
    logic [5:0] legal [5] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02};
    logic [5:0] bad;
    rst = 1'b1; mem_ready = 1'b0; opcode = 6'h00;
    do_reset();

    // Directed: R-type, lw with 3 read stalls, beq, j.
    run_instr(6'h00, 0, 0);
    run_instr(6'h23, 0, 3);
    run_instr(6'h04, 0, 0);
    run_instr(6'h02, 0, 0);
    // Ready arriving on the 16th stalled cycle still completes.
    run_instr(6'h00, 15, 0);
    run_instr(6'h2b, 2, 15);

    // Illegal opcodes trap sticky.
    for (int k = 0; k < 3; k++) begin
      bad = (k == 0) ? 6'h3f : rnd_op();
      while (is_legal(bad)) bad = rnd_op();
      step(1'b1, ST_FETCH, rnd_op());
      step(rbit(), ST_DECODE, bad);
      exp_ill = 1'b1;
      for (int i = 0; i < 20; i++) step(rbit(), ST_TRAP, rnd_op());
      do_reset();
    end

    // Fetch watchdog: 16 stalled cycles then trap.
    for (int i = 0; i < 16; i++) step(1'b0, ST_FETCH, rnd_op());
    exp_to = 1'b1;
    for (int i = 0; i < 5; i++) step(rbit(), ST_TRAP, rnd_op());
    do_reset();

    // Store-write watchdog.
    step(1'b1, ST_FETCH, rnd_op());
    step(rbit(), ST_DECODE, 6'h2b);
    step(rbit(), ST_MADDR, 6'h2b);
    for (int i = 0; i < 16; i++) step(1'b0, ST_MWR, rnd_op());
    exp_to = 1'b1;
    for (int i = 0; i < 3; i++) step(rbit(), ST_TRAP, rnd_op());
    do_reset();

    // Reset in the middle of a store aborts asynchronously.
    step(1'b1, ST_FETCH, rnd_op());
    step(rbit(), ST_DECODE, 6'h2b);
    step(rbit(), ST_MADDR, 6'h2b);
    step(1'b0, ST_MWR, rnd_op());
    chk("mem_write_pre", 32'(mem_write), 1);
    #1 rst = 1'b1;
    #1;
    chk("abort_mem_write", 32'(mem_write), 0);
    chk("abort_state", 32'(state), ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_idle", 32'(state), ST_IDLE);
    run_instr(6'h00, 0, 0);

    // Random legal instruction stream with random stalls.
    for (int n = 0; n < 40; n++)
      run_instr(legal[$urandom_range(4)], $urandom_range(3) == 0 ? $urandom_range(15) : 0,
                $urandom_range(15));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS datapath: FETCH, DECODE, then per-opcode execute, memory and writeback states.
- Replaces single-cycle decode for the multi-cycle build.
- Drives PC, IR, memory, ALU-mux and register-file enables; stalls on a memory ready handshake.
- Watchdog traps hung memory; illegal opcodes trap sticky.

Parameters:
- WAIT_MAX, 15: max consecutive cycles one memory access may wait (mem_ready low) before trapping; legal range 1..255.
- WAIT_W, 8: wait-counter width; must hold WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]; stable from DECODE until return to FETCH
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  write register: 1=rd, 0=rt
- memto_reg  out  1  writeback source: 1=MDR, 0=ALUOut
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  ALU A: 0=PC, 1=A reg
- alu_src_b  out  2  ALU B: 00=B reg, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse in an instruction's final cycle
- illegal_op  out  1  sticky illegal-opcode trap
- mem_timeout  out  1  sticky watchdog trap
- state  out  4  current state, for debug

Behaviour:
- State encoding: IDLE=0 FETCH=1 DECODE=2 MEM_ADDR=3 MEM_RD=4 MEM_WB=5 MEM_WR=6 EXEC=7 R_WB=8 BRANCH=9 JUMP=10 TRAP=11.
- rst asserted: state=IDLE, wait counter=0, illegal_op=mem_timeout=0. Every output is 0 in IDLE.
- rst mid-instruction aborts immediately; no partial write is re-issued.
- Output timing:
  - Outputs decode from state only (Moore).
  - Exceptions: ir_write, pc_write in FETCH, and instr_done in MEM_WR are additionally gated by mem_ready.
- IDLE: next state FETCH.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Holds until mem_ready, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - other -> TRAP, setting illegal_op
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, memto_reg=1, reg_dst=0, instr_done=1. Next: FETCH.
- MEM_WR: mem_write=1, i_or_d=1. On mem_ready: instr_done=1, next FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next: R_WB.
- R_WB: reg_write=1, reg_dst=1, memto_reg=0, instr_done=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next: FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next: FETCH.
- TRAP: all enables 0; held until rst; trap flags stay asserted.
- Latency with mem_ready tied 1: R-type 4 cycles, lw 5, sw 4, beq 3, j 3.
- Watchdog:
  - Counter increments each FETCH/MEM_RD/MEM_WR cycle with mem_ready=0.
  - Clears on mem_ready or on any state change.
  - If the counter equals WAIT_MAX and mem_ready=0, the next state is TRAP and mem_timeout is set.
  - mem_ready arriving in that same cycle wins: the access completes normally.
- Opcode changing outside FETCH/DECODE is ignored; only the value sampled in DECODE (and MEM_ADDR for lw/sw) matters.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_count[31:0] and instr_count[31:0], both reset to 0.
  - cycle_count increments every cycle out of IDLE/TRAP.
  - instr_count increments on instr_done.
  - Both wrap at 2^32-1 -> 0 silently.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - state localparams
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J
  - ALU_OP_ADD/SUB/FUNCT
  - ALUSRCB_* and PCSRC_* encodings
- Sub-module mem_wait_watchdog holds the wait counter and compare. Inputs: clk, rst, waiting, clear. Output: expired.
- FSM and output decode remain in multicycle_ctrl.

Test Plan:
- Reset, then release with mem_ready=1, opcode=000000 -> states 0,1,2,7,8,1. R_WB shows reg_write=1 and reg_dst=1; instr_done pulses once, at cycle 4 after FETCH entry.
- opcode=100011, mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles. Then MEM_WB with memto_reg=1, reg_write=1; 8 cycles FETCH-to-FETCH.
- opcode=000100 -> BRANCH has alu_op=01, pc_write_cond=1, pc_source=01. Return to FETCH after 3 cycles. opcode=000010 -> JUMP has pc_write=1, pc_source=10.
- opcode=111111 -> TRAP at cycle 3, illegal_op=1. Stays in TRAP with all enables 0 for 20 cycles; rst clears it to IDLE.
- mem_ready held 0 in FETCH with WAIT_MAX=15 -> TRAP after the 16th wait cycle, mem_timeout=1. Repeat with mem_ready rising on the 16th cycle -> DECODE, no trap.
- Assert rst during MEM_WR with mem_write=1 -> mem_write drops asynchronously, state=IDLE. Then the FETCH sequence restarts.
